// File: rtl/sharpmz_ioctl_bridge.sv
// sharpmz_ioctl_bridge
// Moves HPS ioctl traffic to and from the Sharp MZ memory regions.
// Downloads are packed into BYTES-wide words, staged for one cycle, queued in
// a write FIFO and steered to the region selected by ioctl_index.
// Uploads are served through a single-word read cache.
// ioctl_wait applies back-pressure from FIFO occupancy during downloads and
// from read latency during uploads.
module sharpmz_ioctl_bridge #(
   parameter int IOCTL_AW   = 25,
   parameter int MEM_AW     = 24,
   parameter int BYTES      = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_CHAN   = 4,
   localparam int CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ioctl_download,
   input  logic                  ioctl_upload,
   input  logic [7:0]            ioctl_index,
   input  logic                  ioctl_wr,
   input  logic                  ioctl_rd,
   input  logic [IOCTL_AW-1:0]   ioctl_addr,
   input  logic [7:0]            ioctl_dout,
   output logic [7:0]            ioctl_din,
   output logic                  ioctl_wait,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [CHAN_W-1:0]     mem_chan,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [8*BYTES-1:0]    mem_wdata,
   output logic [BYTES-1:0]      mem_be,
   input  logic                  mem_ack,
   input  logic [8*BYTES-1:0]    mem_rdata,
   output logic                  xfer_active,
   output logic                  xfer_err
);

   localparam int LB  = $clog2(BYTES);
   localparam int LBW = (LB > 0) ? LB : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int DW  = 8 * BYTES;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DL,
      S_DRAIN,
      S_UL,
      S_UL_REQ
   } state_t;

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      logic [MEM_AW-1:0] addr;
      logic [DW-1:0]     data;
      logic [BYTES-1:0]  be;
   } entry_t;

   state_t              state;
   logic                dl_q, ul_q;
   logic [CHAN_W-1:0]   chan;
   logic                void_sess;

   logic                pack_valid;
   logic [MEM_AW-1:0]   pack_addr;
   logic [DW-1:0]       pack_data;
   logic [BYTES-1:0]    pack_be;

   logic                push_q_valid;
   entry_t              push_q;

   entry_t              fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [PW:0]         count;

   logic                cache_valid;
   logic [MEM_AW-1:0]   cache_addr;
   logic [DW-1:0]       cache_data;
   logic [MEM_AW-1:0]   rd_addr;
   logic [LBW-1:0]      rd_lane;

   // Byte address split into word address and byte lane.
   logic [MEM_AW-1:0]   req_word;
   logic [LBW-1:0]      req_lane;
   assign req_word = MEM_AW'(ioctl_addr >> LB);
   assign req_lane = (LB == 0) ? '0 : LBW'(ioctl_addr);

   function automatic logic [7:0] lane_of(input logic [DW-1:0] w, input logic [LBW-1:0] l);
      lane_of = w[8*l +: 8];
   endfunction

   // Pack merge: decide the next pack contents and what (if anything) to stage for the FIFO.
   logic                do_wr, same_word;
   logic [DW-1:0]       merge_data;
   logic [BYTES-1:0]    merge_be;
   logic                push_en;
   logic [MEM_AW-1:0]   push_addr;
   logic [DW-1:0]       push_data;
   logic [BYTES-1:0]    push_be;
   logic                pack_valid_n;
   logic [MEM_AW-1:0]   pack_addr_n;
   logic [DW-1:0]       pack_data_n;
   logic [BYTES-1:0]    pack_be_n;

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      do_wr        = (state == S_DL) && ioctl_wr && !void_sess;
      same_word    = pack_valid && (pack_addr == req_word);
      merge_data   = same_word ? pack_data : '0;
      merge_be     = same_word ? pack_be   : '0;
      merge_data[8*req_lane +: 8] = ioctl_dout;
      merge_be[req_lane]          = 1'b1;

      push_en      = 1'b0;
      push_addr    = pack_addr;
      push_data    = pack_data;
      push_be      = pack_be;
      pack_valid_n = pack_valid;
      pack_addr_n  = pack_addr;
      pack_data_n  = pack_data;
      pack_be_n    = pack_be;

      if (do_wr) begin
         if (pack_valid && !same_word) begin
            // Old word goes out; the new byte starts a fresh pack even if it is the
            // top lane, so one write never needs two pushes.
            push_en      = 1'b1;
            pack_valid_n = 1'b1;
            pack_addr_n  = req_word;
            pack_data_n  = merge_data;
            pack_be_n    = merge_be;
         end else if (req_lane == LBW'(BYTES - 1)) begin
            push_en      = 1'b1;
            push_addr    = req_word;
            push_data    = merge_data;
            push_be      = merge_be;
            pack_valid_n = 1'b0;
         end else begin
            pack_valid_n = 1'b1;
            pack_addr_n  = req_word;
            pack_data_n  = merge_data;
            pack_be_n    = merge_be;
         end
      end else if ((state == S_DRAIN) && pack_valid) begin
         // Flush a partial word once the session has ended.
         push_en      = 1'b1;
         pack_valid_n = 1'b0;
      end
   end

   // FIFO bookkeeping and the look-ahead occupancy that drives download back-pressure.
   logic                pop, full, fifo_push;
   logic [PW:0]         count_next;
   logic [PW+1:0]       total_next;
   logic                wait_fifo;
   logic                ul_hit;

   always_comb begin
      pop        = mem_ack && (count != '0) && (state != S_UL_REQ);
      full       = (count == (PW+1)'(FIFO_DEPTH));
      fifo_push  = push_q_valid && (!full || pop);
      count_next = count + (PW+1)'(fifo_push) - (PW+1)'(pop);
      // The staged entry is counted too, so the write seen alongside a rising wait still fits.
      total_next = {1'b0, count_next} + (PW+2)'(push_en);
      wait_fifo  = (total_next >= (PW+2)'(FIFO_DEPTH - 1));
      ul_hit     = cache_valid && (cache_addr == req_word);
   end

   // Memory port: upload read in UL_REQ, otherwise the FIFO head; all zero when idle.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_chan  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (state == S_UL_REQ) begin
         mem_req  = 1'b1;
         mem_chan = chan;
         mem_addr = rd_addr;
         mem_be   = '1;
      end else if (count != '0) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_chan  = fifo_mem[rd_ptr].chan;
         mem_addr  = fifo_mem[rd_ptr].addr;
         mem_wdata = fifo_mem[rd_ptr].data;
         mem_be    = fifo_mem[rd_ptr].be;
      end
   end

   assign xfer_active = (state != S_IDLE);

   // FIFO storage: written at the tail on every accepted push.
   // NOTE: the storage array has no reset; validity is tracked by count and pointers.
   always_ff @(posedge clk_sys) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr] <= push_q;
      end
   end

   // Session FSM with pack, staging, pointers, cache and registered ioctl outputs.
   // NOTE: all state updates here are non-blocking so every register sees pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= S_IDLE;
         dl_q         <= 1'b0;
         ul_q         <= 1'b0;
         chan         <= '0;
         void_sess    <= 1'b0;
         pack_valid   <= 1'b0;
         pack_addr    <= '0;
         pack_data    <= '0;
         pack_be      <= '0;
         push_q_valid <= 1'b0;
         push_q       <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         cache_valid  <= 1'b0;
         cache_addr   <= '0;
         cache_data   <= '0;
         rd_addr      <= '0;
         rd_lane      <= '0;
         ioctl_din    <= '0;
         ioctl_wait   <= 1'b0;
         xfer_err     <= 1'b0;
      end else begin
         dl_q         <= ioctl_download;
         ul_q         <= ioctl_upload;

         pack_valid   <= pack_valid_n;
         pack_addr    <= pack_addr_n;
         pack_data    <= pack_data_n;
         pack_be      <= pack_be_n;

         push_q_valid <= push_en;
         push_q       <= '{chan: chan, addr: push_addr, data: push_data, be: push_be};

         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)       rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         if (push_q_valid && !fifo_push) xfer_err <= 1'b1;

         case (state)
            S_IDLE: begin
               ioctl_wait <= 1'b0;
               if ((ioctl_download && !dl_q) || (ioctl_upload && !ul_q)) begin
                  chan        <= CHAN_W'(ioctl_index);
                  void_sess   <= (32'(ioctl_index) >= NUM_CHAN);
                  xfer_err    <= (32'(ioctl_index) >= NUM_CHAN);
                  cache_valid <= 1'b0;
                  state       <= (ioctl_download && !dl_q) ? S_DL : S_UL;
               end
            end
            S_DL: begin
               ioctl_wait <= wait_fifo;
               if (!ioctl_download) state <= S_DRAIN;
            end
            S_DRAIN: begin
               ioctl_wait <= wait_fifo;
               if (!pack_valid && !push_q_valid && (count == '0)) state <= S_IDLE;
            end
            S_UL: begin
               ioctl_wait <= 1'b0;
               if (ioctl_rd) begin
                  if (void_sess) begin
                     ioctl_din <= 8'hFF;
                  end else if (ul_hit) begin
                     ioctl_din <= lane_of(cache_data, req_lane);
                  end else begin
                     rd_addr    <= req_word;
                     rd_lane    <= req_lane;
                     ioctl_wait <= 1'b1;
                     state      <= S_UL_REQ;
                  end
               end else if (!ioctl_upload) begin
                  state <= S_IDLE;
               end
            end
            S_UL_REQ: begin
               if (mem_ack) begin
                  cache_valid <= 1'b1;
                  cache_addr  <= rd_addr;
                  cache_data  <= mem_rdata;
                  ioctl_din   <= lane_of(mem_rdata, rd_lane);
                  ioctl_wait  <= 1'b0;
                  state       <= S_UL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sharpmz_ioctl_bridge.sv
// Testbench for sharpmz_ioctl_bridge: directed sessions on a BYTES=2 instance checked by a
// scoreboard monitor, plus a BYTES=1 instance for the simultaneous push/pop case.
module tb_sharpmz_ioctl_bridge;

   logic        clk_sys = 1'b0;
   logic        reset;
   always #5 clk_sys = ~clk_sys;

   // Main instance (default parameters)
   logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
   logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait, mem_req, mem_we, mem_ack, xfer_active, xfer_err;
   logic [1:0]  mem_chan, mem_be;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   sharpmz_ioctl_bridge dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_we(mem_we),
      .mem_chan(mem_chan), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .xfer_active(xfer_active), .xfer_err(xfer_err)
   );

   // Byte-wide instance
   logic        b1_download, b1_wr, b1_ack;
   logic [7:0]  b1_index, b1_dout, b1_din, b1_wdata;
   logic [23:0] b1_addr, b1_mem_addr;
   logic        b1_wait, b1_req, b1_we, b1_active, b1_err;
   logic [1:0]  b1_chan;
   logic [0:0]  b1_be;

   sharpmz_ioctl_bridge #(.IOCTL_AW(24), .MEM_AW(24), .BYTES(1), .FIFO_DEPTH(8), .NUM_CHAN(4)) u1 (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(b1_download), .ioctl_upload(1'b0),
      .ioctl_index(b1_index), .ioctl_wr(b1_wr), .ioctl_rd(1'b0),
      .ioctl_addr(b1_addr), .ioctl_dout(b1_dout), .ioctl_din(b1_din),
      .ioctl_wait(b1_wait), .mem_req(b1_req), .mem_we(b1_we),
      .mem_chan(b1_chan), .mem_addr(b1_mem_addr), .mem_wdata(b1_wdata),
      .mem_be(b1_be), .mem_ack(b1_ack), .mem_rdata(8'h00),
      .xfer_active(b1_active), .xfer_err(b1_err)
   );

   typedef struct packed {
      logic        we;
      logic [1:0]  chan;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
   } exp_t;

   exp_t       wq[$];
   logic [7:0] rd_q[$];
   int         n_pass = 0;
   int         n_total = 0;
   int         writes_done = 0;
   bit         ack_en = 1'b1;
   int         ack_delay = 0;
   int         ack_cnt = 0;
   bit         rd_pend = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting, required event did not occur", name);
   endtask

   function automatic exp_t mk(input logic we, input logic [1:0] ch, input logic [23:0] a,
                               input logic [15:0] d, input logic [1:0] be);
      mk = '{we: we, chan: ch, addr: a, wdata: d, be: be};
   endfunction

   function automatic logic [63:0] main_outs();
      main_outs = {7'd0, ioctl_din, ioctl_wait, mem_req, mem_we, mem_chan, mem_addr,
                   mem_wdata, mem_be, xfer_active, xfer_err};
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Memory responder: acks a request ack_delay cycles after it first appears.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hBEEF;
      forever begin
         @(posedge clk_sys);
         #1;
         if (ack_en && mem_req) begin
            if (ack_cnt >= ack_delay) begin
               mem_ack = 1'b1;
               ack_cnt = 0;
            end else begin
               mem_ack = 1'b0;
               ack_cnt++;
            end
         end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
         end
      end
   end

   // Monitor: compares every accepted memory transaction and every upload byte against the queues.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (!reset) begin
            if (mem_req && mem_ack) begin
               if (wq.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_mem_txn: we=%0b chan=%0h addr=%0h wdata=%0h, required no request",
                           mem_we, mem_chan, mem_addr, mem_wdata);
               end else begin
                  exp_t e;
                  e = wq.pop_front();
                  check("mem_we", 64'(mem_we), 64'(e.we));
                  check("mem_chan", 64'(mem_chan), 64'(e.chan));
                  check("mem_addr", 64'(mem_addr), 64'(e.addr));
                  check("mem_be", 64'(mem_be), 64'(e.be));
                  if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
               end
            end
            if (rd_pend && !ioctl_wait) begin
               rd_pend = 1'b0;
               if (rd_q.size() == 0) begin
                  n_total++;
                  $display("FAIL ioctl_din_unexpected: got %0h, required no read", ioctl_din);
               end else begin
                  check("ioctl_din", 64'(ioctl_din), 64'(rd_q.pop_front()));
               end
            end
            if (ioctl_rd) rd_pend = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      int n = 0;
      while (ioctl_wait && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) fail_timeout("wr_wait_release");
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      writes_done++;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic rd_byte(input logic [24:0] a, input logic [7:0] exp_din, output int hi);
      rd_q.push_back(exp_din);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd   = 1'b0;
      hi = 0;
      while (ioctl_wait && hi < 50) begin
         hi++;
         tick();
      end
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic end_dl(input string name);
      int n = 0;
      ioctl_download = 1'b0;
      tick();
      while (xfer_active && n < 300) begin
         tick();
         n++;
      end
      check({name, "_xfer_active_fall"}, 64'(xfer_active), 64'd0);
      check({name, "_all_drained"}, 64'(wq.size()), 64'd0);
      tick();
   endtask

   initial begin
      int hi;
      int n;
      reset = 1'b1;
      ioctl_download = 0; ioctl_upload = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_rd = 0;
      ioctl_addr = 0; ioctl_dout = 0;
      b1_download = 0; b1_index = 0; b1_wr = 0; b1_addr = 0; b1_dout = 0; b1_ack = 0;
      repeat (3) tick();
      check("reset_outputs", main_outs(), 64'd0);
      reset = 1'b0;
      tick();

      // Pack two bytes into one word, leave a partial word for the drain flush.
      wq.push_back(mk(1'b1, 2'd1, 24'd0, 16'h2211, 2'b11));
      wq.push_back(mk(1'b1, 2'd1, 24'd1, 16'h0033, 2'b01));
      start_dl(8'd1);
      wr_byte(25'd0, 8'h11);
      wr_byte(25'd1, 8'h22);
      wr_byte(25'd2, 8'h33);
      end_dl("pack");
      check("pack_xfer_err", 64'(xfer_err), 64'd0);

      // Back-pressure: ack held low, 20 writes fill the FIFO to the wait threshold.
      for (int k = 0; k < 10; k++)
         wq.push_back(mk(1'b1, 2'd2, 24'(k), {8'(8'h41 + 2*k), 8'(8'h40 + 2*k)}, 2'b11));
      ack_en = 1'b0;
      start_dl(8'd2);
      writes_done = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) wr_byte(25'(i), 8'(8'h40 + i));
         end
         begin
            n = 0;
            while (!ioctl_wait && n < 200) begin
               tick();
               n++;
            end
            check("bp_wait_high", 64'(ioctl_wait), 64'd1);
            check("bp_writes_at_wait", 64'(writes_done), 64'd14);
            repeat (5) tick();
            check("bp_wait_holds", 64'(ioctl_wait), 64'd1);
            check("bp_req_pending", 64'(mem_req), 64'd1);
            check("bp_writes_stalled", 64'(writes_done), 64'd14);
            ack_en = 1'b1;
         end
      join
      end_dl("bp");
      check("bp_xfer_err", 64'(xfer_err), 64'd0);

      // Void session: index beyond NUM_CHAN.
      start_dl(8'd5);
      check("void_err_set", 64'(xfer_err), 64'd1);
      wr_byte(25'd0, 8'hAA);
      wr_byte(25'd1, 8'hBB);
      repeat (3) tick();
      check("void_no_req", 64'(mem_req), 64'd0);
      end_dl("void");
      wq.push_back(mk(1'b1, 2'd0, 24'd3, 16'h6655, 2'b11));
      start_dl(8'd0);
      check("void_err_cleared", 64'(xfer_err), 64'd0);
      wr_byte(25'd6, 8'h55);
      wr_byte(25'd7, 8'h66);
      end_dl("after_void");

      // Upload: miss with a 3-cycle ack, then a cache hit on the other lane.
      ack_delay = 3;
      wq.push_back(mk(1'b0, 2'd1, 24'd2, 16'h0000, 2'b11));
      ioctl_index  = 8'd1;
      ioctl_upload = 1'b1;
      tick();
      rd_byte(25'd4, 8'hEF, hi);
      check("ul_miss_wait_cycles", 64'(hi), 64'd4);
      rd_byte(25'd5, 8'hBE, hi);
      check("ul_hit_wait_cycles", 64'(hi), 64'd0);
      tick();
      ioctl_upload = 1'b0;
      repeat (2) tick();
      check("ul_xfer_active_fall", 64'(xfer_active), 64'd0);
      ack_delay = 0;

      // Void upload returns 0xFF without a request.
      ioctl_index  = 8'd9;
      ioctl_upload = 1'b1;
      tick();
      check("void_ul_err", 64'(xfer_err), 64'd1);
      rd_byte(25'd0, 8'hFF, hi);
      check("void_ul_wait_cycles", 64'(hi), 64'd0);
      ioctl_upload = 1'b0;
      repeat (2) tick();

      // Reset while a write request is outstanding.
      ack_en = 1'b0;
      start_dl(8'd3);
      wr_byte(25'd8, 8'h77);
      wr_byte(25'd9, 8'h88);
      n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      check("rst_req_before", 64'(mem_req), 64'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      tick();
      reset = 1'b0;
      check("rst_outputs_cleared", main_outs(), 64'd0);
      ack_en = 1'b1;
      tick();
      wq.push_back(mk(1'b1, 2'd3, 24'd4, 16'h8877, 2'b11));
      start_dl(8'd3);
      wr_byte(25'd8, 8'h77);
      wr_byte(25'd9, 8'h88);
      end_dl("after_reset");

      // Byte-wide instance: push and pop in the same cycle at count 3.
      b1_index    = 8'd0;
      b1_download = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("b1_wait_low_fill", 64'(b1_wait), 64'd0);
         b1_addr = 24'(i);
         b1_dout = 8'(8'h10 + i);
         b1_wr   = 1'b1;
         tick();
      end
      b1_wr = 1'b0;
      check("b1_req_at_pushpop", 64'(b1_req), 64'd1);
      check("b1_head_at_pushpop", 64'(b1_mem_addr), 64'd0);
      b1_ack = 1'b1;
      tick();
      b1_ack = 1'b0;
      check("b1_wait_after_pushpop", 64'(b1_wait), 64'd0);
      tick();
      for (int k = 1; k < 4; k++) begin
         check("b1_drain_req", 64'(b1_req), 64'd1);
         check("b1_drain_addr", 64'(b1_mem_addr), 64'(k));
         check("b1_drain_data", 64'(b1_wdata), 64'(8'h10 + k));
         b1_ack = 1'b1;
         tick();
      end
      b1_ack = 1'b0;
      check("b1_count_was_3", 64'(b1_req), 64'd0);
      b1_download = 1'b0;
      repeat (4) tick();
      check("b1_xfer_active_fall", 64'(b1_active), 64'd0);
      check("b1_xfer_err", 64'(b1_err), 64'd0);

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
